// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - byte-stream program loader for the MIPS instruction memory
// Assembles big-endian words from a valid/ready byte stream and holds the CPU in reset until loaded.
module inst_mem_loader #(
   parameter int ADDR_WIDTH = 6,
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WORD_WIDTH-1:0] mem_wdata,
   output logic                  cpu_rst,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, DONE, ERROR} state_t;

   localparam logic [15:0] CAPACITY = 16'(2 ** ADDR_WIDTH);

   state_t                state, state_n;
   logic [15:0]           len, len_n;
   logic [1:0]            byte_idx, byte_idx_n;
   logic [ADDR_WIDTH-1:0] word_idx, word_idx_n;
   logic [23:0]           asm_q, asm_n;
   logic                  mem_we_n;
   logic [ADDR_WIDTH-1:0] mem_addr_n;
   logic [WORD_WIDTH-1:0] mem_wdata_n;
   logic [ADDR_WIDTH:0]   words_loaded_n;
   logic [15:0]           len_full;
   logic                  accept;

   assign accept   = in_valid && in_ready;
   assign len_full = {len[15:8], in_data};

   always_comb begin
      state_n        = state;
      len_n          = len;
      byte_idx_n     = byte_idx;
      word_idx_n     = word_idx;
      asm_n          = asm_q;
      mem_we_n       = 1'b0;
      mem_addr_n     = mem_addr;
      mem_wdata_n    = mem_wdata;
      words_loaded_n = words_loaded;

      case (state)
         LEN_HI: begin
            if (accept) begin
               len_n   = {in_data, 8'h00};
               state_n = LEN_LO;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_n          = len_full;
               byte_idx_n     = 2'd0;
               word_idx_n     = '0;
               words_loaded_n = '0;
               if (len_full == 16'd0)
                  state_n = DONE;
               else if (len_full > CAPACITY)
                  state_n = ERROR;
               else
                  state_n = DATA;
            end
         end
         DATA: begin
            if (accept) begin
               asm_n      = {asm_q[15:0], in_data};
               byte_idx_n = byte_idx + 2'd1;
               if (byte_idx == 2'd3) begin
                  mem_we_n       = 1'b1;
                  mem_addr_n     = word_idx;
                  mem_wdata_n    = {asm_q, in_data};
                  word_idx_n     = word_idx + 1'b1;
                  words_loaded_n = words_loaded + 1'b1;
                  // The final write and the DONE transition share one edge.
                  if (16'(words_loaded) + 16'd1 == len)
                     state_n = DONE;
               end
            end
         end
         DONE, ERROR: begin
            if (start) begin
               state_n        = LEN_HI;
               words_loaded_n = '0;
            end
         end
         default: state_n = LEN_HI;
      endcase
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LEN_HI;
         len          <= '0;
         byte_idx     <= '0;
         word_idx     <= '0;
         asm_q        <= '0;
         in_ready     <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         cpu_rst      <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
      end else begin
         state        <= state_n;
         len          <= len_n;
         byte_idx     <= byte_idx_n;
         word_idx     <= word_idx_n;
         asm_q        <= asm_n;
         in_ready     <= (state_n == LEN_HI) || (state_n == LEN_LO) || (state_n == DATA);
         mem_we       <= mem_we_n;
         mem_addr     <= mem_addr_n;
         mem_wdata    <= mem_wdata_n;
         cpu_rst      <= (state_n != DONE);
         busy         <= (state_n == LEN_HI) || (state_n == LEN_LO) || (state_n == DATA);
         done         <= (state_n == DONE);
         error        <= (state_n == ERROR);
         words_loaded <= words_loaded_n;
      end
   end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - directed self-checking bench for inst_mem_loader
// Streams hand-built images and checks write port, status outputs and reset behaviour.
module tb_inst_mem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mem_we;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        error;
   logic [6:0]  words_loaded;

   int checks = 0;
   int failures = 0;
   int wr_cnt = 0;
   logic [5:0]  wr_addr [512];
   logic [31:0] wr_data [512];
   logic [31:0] img [64];

   inst_mem_loader #(.ADDR_WIDTH(6), .WORD_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_addr[wr_cnt] = mem_addr;
         wr_data[wr_cnt] = mem_wdata;
         wr_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk); #1;
         check("cpu_rst_in_gap", {31'd0, cpu_rst}, 32'd1);
      end
   endtask

   task automatic check_reset_values();
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_words_loaded", {25'd0, words_loaded}, 32'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_done", {31'd0, done}, 32'd0);
      check("start_error", {31'd0, error}, 32'd0);
      check("start_words_loaded", {25'd0, words_loaded}, 32'd0);
   endtask

   // Streams header + n words of img, then checks completion status and captured writes.
   task automatic run_load(input int n, input int gap);
      int base = wr_cnt;
      logic [15:0] nn = 16'(n);
      send_byte(nn[15:8], gap);
      send_byte(nn[7:0], (n == 0) ? 0 : gap);
      for (int w = 0; w < n; w++) begin
         logic [31:0] word = img[w];
         send_byte(word[31:24], gap);
         send_byte(word[23:16], gap);
         send_byte(word[15:8], gap);
         send_byte(word[7:0], (w == n - 1) ? 0 : gap);
      end
      check("load_done", {31'd0, done}, 32'd1);
      check("load_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      check("load_in_ready", {31'd0, in_ready}, 32'd0);
      check("load_busy", {31'd0, busy}, 32'd0);
      check("load_words_loaded", {25'd0, words_loaded}, 32'(n));
      @(posedge clk); #1;
      check("load_write_count", 32'(wr_cnt - base), 32'(n));
      for (int w = 0; w < n && base + w < wr_cnt; w++) begin
         check("load_wr_addr", {26'd0, wr_addr[base + w]}, 32'(w));
         check("load_wr_data", wr_data[base + w], img[w]);
      end
   endtask

   initial begin
      int base;
      // Test 1: reset state, then full-rate 3-word image.
      repeat (3) @(posedge clk);
      #1;
      check_reset_values();
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("post_rst_busy", {31'd0, busy}, 32'd1);
      img[0] = 32'h8FE10000;
      img[1] = 32'h8FE20000;
      img[2] = 32'h00221820;
      run_load(3, 0);

      // Test 2: same image with 3 idle cycles between bytes.
      pulse_start();
      run_load(3, 3);

      // Test 3: empty image.
      pulse_start();
      run_load(0, 0);

      // Test 4: oversize count, then recover and fill memory.
      pulse_start();
      base = wr_cnt;
      send_byte(8'h00, 0);
      send_byte(8'h41, 0);
      check("err_error", {31'd0, error}, 32'd1);
      check("err_in_ready", {31'd0, in_ready}, 32'd0);
      check("err_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      check("err_busy", {31'd0, busy}, 32'd0);
      check("err_done", {31'd0, done}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("err_no_writes", 32'(wr_cnt - base), 32'd0);
      pulse_start();
      for (int i = 0; i < 64; i++) img[i] = {8'(i), 8'h5A, ~8'(i), 8'(i * 3)};
      run_load(64, 0);

      // Test 6: reload a 1-word image from DONE.
      pulse_start();
      img[0] = 32'h1022FFE5;
      run_load(1, 0);

      // Test 5: reset in the middle of a 3-word load.
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h03, 0);
      send_byte(8'h8F, 0);
      send_byte(8'hE1, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h8F, 0);
      send_byte(8'hE2, 0);
      check("mid_words_loaded", {25'd0, words_loaded}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_values();
      rst = 1'b0;
      @(posedge clk); #1;
      img[0] = 32'h12345678;
      run_load(1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
